// File: rtl/memory_responder.sv
// memory_responder
//   Global-memory endpoint sitting behind the memory controller. Holds a
//   2**ADDR_BITS x DATA_BITS array and serves one outstanding read or write
//   per channel, answering a fixed LATENCY rising edges after acceptance.
//   A host load port preloads the array before a kernel launch. With
//   WRITE_ENABLE=0 (program memory) channel writes are acknowledged but the
//   array is left untouched.
//
// Handshake (every channel, read and write alike):
//   A request is accepted on the first rising edge where the channel is
//   IDLE and its valid is high; address/data are captured on that edge.
//   The matching ready is a one-cycle pulse LATENCY edges later. The channel
//   then waits for the served valid to be sampled low before it goes IDLE
//   again, so a valid that stays high is never served twice. If read and
//   write valid are both high in IDLE, the read is taken.
//
// Ports
//   clk                rising-edge clock
//   reset              asynchronous, active-low reset
//   mem_read_valid     per-channel read request
//   mem_read_address   per-channel read address (packed, channel 0 in LSBs)
//   mem_read_ready     per-channel one-cycle read response pulse
//   mem_read_data      per-channel read data, held until the next read response
//   mem_write_valid    per-channel write request
//   mem_write_address  per-channel write address (packed)
//   mem_write_data     per-channel write data (packed)
//   mem_write_ready    per-channel one-cycle write commit pulse
//   load_valid         host preload strobe, one word per cycle
//   load_address       host preload address
//   load_data          host preload data
//   debug_state        per-channel FSM state, 2 bits per channel
//                      (0 IDLE, 1 BUSY, 2 RESPOND, 3 WAIT_DROP)

module memory_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 1,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]           mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_ready,
    input  logic                              load_valid,
    input  logic [ADDR_BITS-1:0]              load_address,
    input  logic [DATA_BITS-1:0]              load_data,
    output logic [2*NUM_CHANNELS-1:0]         debug_state
);

    localparam int DEPTH = 1 << ADDR_BITS;
    // Count loaded on acceptance; BUSY lasts LATENCY edges including the access edge.
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        RESPOND   = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Per-channel write commits, gathered so one process owns the array.
    logic [NUM_CHANNELS-1:0]           commit;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] commit_addr;
    logic [NUM_CHANNELS*DATA_BITS-1:0] commit_data;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        state_t               state_q;
        state_t               state_d;
        logic [3:0]           count_q;
        logic [ADDR_BITS-1:0] addr_q;
        logic [DATA_BITS-1:0] wdata_q;
        logic [DATA_BITS-1:0] rdata_q;
        logic                 is_write_q;
        logic                 rd_rdy;
        logic                 wr_rdy;
        logic                 access;
        logic                 served_valid;

        logic                 rv;
        logic                 wv;
        logic [ADDR_BITS-1:0] ra;
        logic [ADDR_BITS-1:0] wa;
        logic [DATA_BITS-1:0] wd;

        assign rv = mem_read_valid[c];
        assign wv = mem_write_valid[c];
        assign ra = mem_read_address[c*ADDR_BITS +: ADDR_BITS];
        assign wa = mem_write_address[c*ADDR_BITS +: ADDR_BITS];
        assign wd = mem_write_data[c*DATA_BITS +: DATA_BITS];

        assign access       = (state_q == BUSY) && (count_q == 4'd0);
        assign served_valid = is_write_q ? wv : rv;

        // State register plus the request datapath it steers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q    <= IDLE;
                count_q    <= 4'd0;
                addr_q     <= '0;
                wdata_q    <= '0;
                rdata_q    <= '0;
                is_write_q <= 1'b0;
            end else begin
                state_q <= state_d;
                case (state_q)
                    IDLE: begin
                        if (rv) begin
                            addr_q     <= ra;
                            is_write_q <= 1'b0;
                            count_q    <= LAT_M1;
                        end else if (wv) begin
                            addr_q     <= wa;
                            wdata_q    <= wd;
                            is_write_q <= 1'b1;
                            count_q    <= LAT_M1;
                        end
                    end
                    BUSY: begin
                        if (count_q != 4'd0) begin
                            count_q <= count_q - 4'd1;
                        end else if (!is_write_q) begin
                            // Nonblocking read: sees the array as it was before this edge.
                            rdata_q <= mem[addr_q];
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:      if (rv || wv) state_d = BUSY;
                BUSY:      if (count_q == 4'd0) state_d = RESPOND;
                RESPOND:   state_d = WAIT_DROP;
                WAIT_DROP: if (!served_valid) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end

        always_comb begin
            rd_rdy = 1'b0;
            wr_rdy = 1'b0;
            if (state_q == RESPOND) begin
                rd_rdy = !is_write_q;
                wr_rdy = is_write_q;
            end
        end

        assign mem_read_ready[c]                       = rd_rdy;
        assign mem_write_ready[c]                      = wr_rdy;
        assign mem_read_data[c*DATA_BITS +: DATA_BITS] = rdata_q;
        assign debug_state[2*c +: 2]                   = state_q;
        assign commit[c]                               = access && is_write_q;
        assign commit_addr[c*ADDR_BITS +: ADDR_BITS]   = addr_q;
        assign commit_data[c*DATA_BITS +: DATA_BITS]   = wdata_q;
    end

    // Array contents survive reset; reset only blocks updates. Load goes
    // first, then channels in ascending order, so the highest-index channel
    // wins on an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (reset) begin
            if (load_valid) begin
                mem[load_address] <= load_data;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if ((WRITE_ENABLE != 0) && commit[c]) begin
                    mem[commit_addr[c*ADDR_BITS +: ADDR_BITS]] <= commit_data[c*DATA_BITS +: DATA_BITS];
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Testbench for memory_responder. Three instances share one load bus:
//   u0: defaults (1 channel, LATENCY 2, writes stored)
//   u1: WRITE_ENABLE 0, LATENCY 15
//   u2: 2 channels, LATENCY 1
// Response streams: 0 u0 rd, 1 u0 wr, 2 u1 rd, 3 u1 wr,
//   4 u2 rd ch0, 5 u2 rd ch1, 6 u2 wr ch0, 7 u2 wr ch1.
// Drivers push {stream, expected cycle, expected data} into exp_q; the
// monitor pops the matching entry when a ready pulse appears.

module tb_memory_responder;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        lv;
    logic [7:0]  la;
    logic [15:0] ld;

    logic        rv0, rrdy0, wv0, wrdy0;
    logic [7:0]  ra0, wa0;
    logic [15:0] rd0, wd0;
    logic [1:0]  dbg0;

    logic        rv1, rrdy1, wv1, wrdy1;
    logic [7:0]  ra1, wa1;
    logic [15:0] rd1, wd1;
    logic [1:0]  dbg1;

    logic [1:0]  rv2, rrdy2, wv2, wrdy2;
    logic [15:0] ra2, wa2;
    logic [31:0] rd2, wd2;
    logic [3:0]  dbg2;

    memory_responder #(.LATENCY(2), .WRITE_ENABLE(1), .NUM_CHANNELS(1)) u0 (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv0), .mem_read_address(ra0), .mem_read_ready(rrdy0), .mem_read_data(rd0),
        .mem_write_valid(wv0), .mem_write_address(wa0), .mem_write_data(wd0), .mem_write_ready(wrdy0),
        .load_valid(lv), .load_address(la), .load_data(ld), .debug_state(dbg0));

    memory_responder #(.LATENCY(15), .WRITE_ENABLE(0), .NUM_CHANNELS(1)) u1 (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv1), .mem_read_address(ra1), .mem_read_ready(rrdy1), .mem_read_data(rd1),
        .mem_write_valid(wv1), .mem_write_address(wa1), .mem_write_data(wd1), .mem_write_ready(wrdy1),
        .load_valid(lv), .load_address(la), .load_data(ld), .debug_state(dbg1));

    memory_responder #(.LATENCY(1), .WRITE_ENABLE(1), .NUM_CHANNELS(2)) u2 (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv2), .mem_read_address(ra2), .mem_read_ready(rrdy2), .mem_read_data(rd2),
        .mem_write_valid(wv2), .mem_write_address(wa2), .mem_write_data(wd2), .mem_write_ready(wrdy2),
        .load_valid(lv), .load_address(la), .load_data(ld), .debug_state(dbg2));

    logic [7:0] rdy;
    assign rdy = {wrdy2[1], wrdy2[0], rrdy2[1], rrdy2[0], wrdy1, rrdy1, wrdy0, rrdy0};

    logic [35:0] exp_q[$];

    function automatic int lat(input int s);
        if (s < 2) return 2;
        if (s < 4) return 15;
        return 1;
    endfunction

    function automatic bit is_read(input int s);
        return (s == 0) || (s == 2) || (s == 4) || (s == 5);
    endfunction

    function automatic logic [15:0] rdat(input int s);
        case (s)
            0:       return rd0;
            2:       return rd1;
            4:       return rd2[15:0];
            5:       return rd2[31:16];
            default: return 16'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [15:0] d);
        exp_q.push_back({4'(s), 16'(cyc + 1 + lat(s)), d});
    endtask

    task automatic set_rd(input int s, input logic v, input logic [7:0] a);
        case (s)
            0: begin rv0 = v; ra0 = a; end
            2: begin rv1 = v; ra1 = a; end
            4: begin rv2[0] = v; ra2[7:0] = a; end
            5: begin rv2[1] = v; ra2[15:8] = a; end
            default: ;
        endcase
    endtask

    task automatic set_wr(input int s, input logic v, input logic [7:0] a, input logic [15:0] d);
        case (s)
            1: begin wv0 = v; wa0 = a; wd0 = d; end
            3: begin wv1 = v; wa1 = a; wd1 = d; end
            6: begin wv2[0] = v; wa2[7:0] = a; wd2[15:0] = d; end
            7: begin wv2[1] = v; wa2[15:8] = a; wd2[31:16] = d; end
            default: ;
        endcase
    endtask

    // Returns on the falling edge where the stream's ready is high.
    task automatic wait_ready(input int s);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy[s]) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_ready stream=%0d: got no ready in 40 cycles, required a pulse", s);
    endtask

    task automatic do_read(input int s, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        set_rd(s, 1'b1, a);
        push(s, d);
        wait_ready(s);
        set_rd(s, 1'b0, a);
        @(negedge clk);
    endtask

    task automatic do_write(input int s, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        set_wr(s, 1'b1, a, d);
        push(s, 16'h0);
        wait_ready(s);
        set_wr(s, 1'b0, a, d);
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        lv = 1'b1; la = a; ld = d;
        @(negedge clk);
        lv = 1'b0;
    endtask

    // Monitor: each ready pulse must match a queued expectation and last one cycle.
    initial begin
        logic [7:0] prev;
        bit found;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int s = 0; s < 8; s++) begin
                    if (rdy[s] && prev[s]) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL pulse_width stream=%0d: got ready high 2 cycles, required 1", s);
                    end else if (rdy[s]) begin
                        found = 1'b0;
                        for (int k = 0; k < exp_q.size(); k++) begin
                            if (!found && exp_q[k][35:32] == 4'(s)) begin
                                found = 1'b1;
                                check($sformatf("resp_cycle s%0d", s), 32'(cyc), 32'(exp_q[k][31:16]));
                                if (is_read(s))
                                    check($sformatf("resp_data s%0d", s), 32'(rdat(s)), 32'(exp_q[k][15:0]));
                                exp_q.delete(k);
                            end
                        end
                        if (!found) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_ready stream=%0d: got pulse at cycle %0d, required none", s, cyc);
                        end
                    end
                end
            end
            prev = reset ? rdy : 8'h0;
        end
    end

    initial begin
        reset = 1'b0;
        lv = 0; la = 0; ld = 0;
        rv0 = 0; ra0 = 0; wv0 = 0; wa0 = 0; wd0 = 0;
        rv1 = 0; ra1 = 0; wv1 = 0; wa1 = 0; wd1 = 0;
        rv2 = 0; ra2 = 0; wv2 = 0; wa2 = 0; wd2 = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rdy), 32'h0);
        check("rst_data_u0", 32'(rd0), 32'h0);
        check("rst_data_u2", rd2, 32'h0);
        check("rst_state", {26'h0, dbg2, dbg0}, 32'h0);
        reset = 1'b1;

        preload(8'h10, 16'hBEEF);
        preload(8'h20, 16'h5A5A);
        preload(8'h40, 16'h0F0F);
        preload(8'h50, 16'hCAFE);
        preload(8'h60, 16'h2222);

        // Preload then read, data held afterwards.
        do_read(0, 8'h10, 16'hBEEF);
        repeat (3) @(negedge clk);
        check("hold_data", 32'(rd0), 32'h0000BEEF);

        // Write then read back; program memory ignores the write.
        do_write(1, 8'h20, 16'h1234);
        do_read(0, 8'h20, 16'h1234);
        do_write(3, 8'h20, 16'h1234);
        do_read(2, 8'h20, 16'h5A5A);

        // Same-edge writes to one address: channel 1 wins.
        @(negedge clk);
        set_wr(6, 1'b1, 8'h30, 16'hAAAA);
        set_wr(7, 1'b1, 8'h30, 16'h5555);
        push(6, 16'h0);
        push(7, 16'h0);
        wait_ready(6);
        set_wr(6, 1'b0, 8'h30, 16'hAAAA);
        set_wr(7, 1'b0, 8'h30, 16'h5555);
        @(negedge clk);
        do_read(4, 8'h30, 16'h5555);
        do_read(5, 8'h30, 16'h5555);

        // Read and write of one address on the same access edge: read sees old data.
        @(negedge clk);
        set_rd(4, 1'b1, 8'h40);
        set_wr(7, 1'b1, 8'h40, 16'h7777);
        push(4, 16'h0F0F);
        push(7, 16'h0);
        wait_ready(4);
        set_rd(4, 1'b0, 8'h40);
        set_wr(7, 1'b0, 8'h40, 16'h7777);
        @(negedge clk);
        do_read(4, 8'h40, 16'h7777);

        // Valid held high past the response: one pulse only, then a fresh one.
        @(negedge clk);
        set_rd(0, 1'b1, 8'h10);
        push(0, 16'hBEEF);
        wait_ready(0);
        repeat (5) @(negedge clk);
        set_rd(0, 1'b0, 8'h10);
        @(negedge clk);
        do_read(0, 8'h10, 16'hBEEF);

        // Read and write valid together: only the read is served.
        @(negedge clk);
        set_rd(0, 1'b1, 8'h20);
        set_wr(1, 1'b1, 8'h20, 16'h9999);
        push(0, 16'h1234);
        wait_ready(0);
        set_rd(0, 1'b0, 8'h20);
        set_wr(1, 1'b0, 8'h20, 16'h9999);
        @(negedge clk);
        do_read(0, 8'h20, 16'h1234);

        // Latency extremes (cycle field of each expectation checks the edge count).
        do_read(2, 8'h10, 16'hBEEF);
        do_read(4, 8'h10, 16'hBEEF);
        do_read(5, 8'h20, 16'h5A5A);

        // Asynchronous reset while a write is in BUSY.
        @(negedge clk);
        set_wr(1, 1'b1, 8'h50, 16'hDEAD);
        @(posedge clk);
        #3;
        check("busy_before_reset", 32'(dbg0), 32'h1);
        reset = 1'b0;
        #1;
        check("async_rst_ready", 32'(rdy), 32'h0);
        check("async_rst_data", 32'(rd0), 32'h0);
        check("async_rst_state", 32'(dbg0), 32'h0);
        set_wr(1, 1'b0, 8'h50, 16'hDEAD);
        // Load during reset must be ignored.
        @(negedge clk);
        lv = 1'b1; la = 8'h60; ld = 16'h1111;
        @(negedge clk);
        lv = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_read(0, 8'h50, 16'hCAFE);
        do_read(0, 8'h60, 16'h2222);
        do_read(0, 8'h10, 16'hBEEF);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
